image_parallel_processing_rst_seq: RTL and testbench

// - Downstream of the 2-output 143 MHz system PLL: watches its locked flag, drives its rst, and releases
//   the system/interconnect reset and the two NIOS CPU resets in a fixed, staggered order.
// - Runs on the 50 MHz reference clock so it keeps running while the PLL is unlocked.
// - Reset outputs assert asynchronously. Deassertion is registered in clk.
// - Qsys reset controllers in the 143 MHz domain re-synchronise the deassert edge.

---
 rtl/image_parallel_processing_rst_pkg.sv | 23 ++
 rtl/image_parallel_processing_sync2.sv | 27 ++
 rtl/image_parallel_processing_rst_seq.sv | 129 ++++++++++++
 tb/tb_image_parallel_processing_rst_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/image_parallel_processing_rst_pkg.sv
// Shared definitions for the reset sequencer that sits downstream of the
// 143 MHz system PLL.
//   state_t    : sequencer FSM encoding
//   LOSS_CNT_W : width of the saturating lock-loss counter
//   max2       : helper used to size the shared cycle counter
package image_parallel_processing_rst_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_SYS   = 3'd3,
        REL_CPU0  = 3'd4,
        RUN       = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/image_parallel_processing_sync2.sv
// Two-flop synchroniser for slow level signals crossing into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages to 0
//   d     : asynchronous input, W bits
//   q     : synchronised output, lags d by two clk edges
module image_parallel_processing_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/image_parallel_processing_rst_seq.sv
// Reset sequencer for the system PLL and the logic it clocks. Runs on the
// 50 MHz reference clock so it keeps running while the PLL is unlocked.
// Pulses pll_rst until lock is seen, waits for lock to stay stable, then
// releases sys, cpu0 and cpu1 resets in that order with a fixed gap.
//   clk           : 50 MHz reference clock
//   reset_n       : asynchronous active-low block reset
//   pll_locked    : PLL locked flag, asynchronous to clk
//   sw_reset_req  : 1-cycle pulse, re-runs the release sequence only
//   pll_rst       : active-high PLL reset
//   sys_reset_n   : interconnect/peripheral reset, active low
//   cpu0_reset_n  : NIOS CPU 0 reset, active low
//   cpu1_reset_n  : NIOS CPU 1 reset, active low
//   seq_done      : high while the sequence is complete (RUN)
//   lock_loss_cnt : saturating count of lock losses seen in RUN
// All outputs come straight from flops; assertion into reset happens on the
// async reset or on a clock edge, deassertion always on a clock edge.
module image_parallel_processing_rst_seq
    import image_parallel_processing_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 10,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic                  pll_rst,
    output logic                  sys_reset_n,
    output logic                  cpu0_reset_n,
    output logic                  cpu1_reset_n,
    output logic                  seq_done,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_P = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                max2(STABLE_CYCLES, STAGGER_CYCLES));
    localparam int CNT_W = $clog2(MAX_P) + 1;

    // Terminal counts: the counter starts at 0 on state entry, so a state
    // that must last N cycles leaves when the counter shows N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             lk_s;
    logic             run_loss;

    image_parallel_processing_sync2 #(.W(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Lock loss is checked before sw_reset_req so a simultaneous request is
    // dropped and the PLL is re-qualified from WAIT_LOCK.
    always_comb begin
        next_state = state;
        run_loss   = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == PLL_RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk_s)                     next_state = STABLE;
                else if (cnt == TIMEOUT_LAST) next_state = PLL_RST;
            end
            STABLE: begin
                if (!lk_s)                   next_state = WAIT_LOCK;
                else if (cnt == STABLE_LAST) next_state = REL_SYS;
            end
            REL_SYS: begin
                if (!lk_s)                    next_state = WAIT_LOCK;
                else if (sw_reset_req)        next_state = STABLE;
                else if (cnt == STAGGER_LAST) next_state = REL_CPU0;
            end
            REL_CPU0: begin
                if (!lk_s)                    next_state = WAIT_LOCK;
                else if (sw_reset_req)        next_state = STABLE;
                else if (cnt == STAGGER_LAST) next_state = RUN;
            end
            RUN: begin
                if (!lk_s) begin
                    next_state = WAIT_LOCK;
                    run_loss   = 1'b1;
                end else if (sw_reset_req) begin
                    next_state = STABLE;
                end
            end
            default: next_state = PLL_RST;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they change on
    // the same edge the state does and the release order is fixed by the
    // state order alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            sys_reset_n   <= 1'b0;
            cpu0_reset_n  <= 1'b0;
            cpu1_reset_n  <= 1'b0;
            seq_done      <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) cnt <= '0;
            else if (state != RUN)   cnt <= cnt + 1'b1;

            pll_rst      <= (next_state == PLL_RST);
            sys_reset_n  <= (next_state inside {REL_SYS, REL_CPU0, RUN});
            cpu0_reset_n <= (next_state inside {REL_CPU0, RUN});
            cpu1_reset_n <= (next_state == RUN);
            seq_done     <= (next_state == RUN);

            if (run_loss && (lock_loss_cnt != '1))
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_image_parallel_processing_rst_seq.sv
// Directed bench for the PLL reset sequencer with shortened parameters.
// Cycle c is the interval after the c-th clk edge following reset release;
// outputs are sampled 1 ns after each edge, inputs written for cycle c are
// first seen by edge c+1. Expected release edge after lock driven in cycle E:
// E + 2 (sync) + 1 (WAIT_LOCK->STABLE) + 16 (STABLE) = E + 19.
module tb_image_parallel_processing_rst_seq;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       cpu0_reset_n;
    logic       cpu1_reset_n;
    logic       seq_done;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    image_parallel_processing_rst_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .STABLE_CYCLES  (16),
        .STAGGER_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .pll_rst       (pll_rst),
        .sys_reset_n   (sys_reset_n),
        .cpu0_reset_n  (cpu0_reset_n),
        .cpu1_reset_n  (cpu1_reset_n),
        .seq_done      (seq_done),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pll_rst, sys_reset_n, cpu0_reset_n, cpu1_reset_n, seq_done}
    function automatic logic [4:0] outs();
        return {pll_rst, sys_reset_n, cpu0_reset_n, cpu1_reset_n, seq_done};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // sel: 0 sys_reset_n, 1 cpu0_reset_n, 2 cpu1_reset_n
    task automatic wait_sig(input int sel, input logic val, input int budget,
                            input string name);
        int n;
        logic cur;
        n = 0;
        cur = (sel == 0) ? sys_reset_n : (sel == 1) ? cpu0_reset_n : cpu1_reset_n;
        while (cur != val && n < budget) begin
            step();
            n++;
            cur = (sel == 0) ? sys_reset_n : (sel == 1) ? cpu0_reset_n : cpu1_reset_n;
        end
        chk(name, int'(cur), int'(val));
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("in_reset_outs", int'(outs()), 5'b10000);
        chk("in_reset_loss", int'(lock_loss_cnt), 0);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    typedef struct {
        int         cyc;
        logic       lock;
        logic [4:0] exp;
    } vec_t;

    vec_t pu_tab[11];

    initial begin
        // power-up: lock driven in cycle 19 -> sys 38, cpu0 46, cpu1/done 54
        pu_tab[0]  = '{0,  1'b0, 5'b10000};
        pu_tab[1]  = '{3,  1'b0, 5'b10000};
        pu_tab[2]  = '{4,  1'b0, 5'b00000};
        pu_tab[3]  = '{19, 1'b1, 5'b00000};
        pu_tab[4]  = '{37, 1'b1, 5'b00000};
        pu_tab[5]  = '{38, 1'b1, 5'b01000};
        pu_tab[6]  = '{45, 1'b1, 5'b01000};
        pu_tab[7]  = '{46, 1'b1, 5'b01100};
        pu_tab[8]  = '{53, 1'b1, 5'b01100};
        pu_tab[9]  = '{54, 1'b1, 5'b01111};
        pu_tab[10] = '{60, 1'b1, 5'b01111};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            goto(pu_tab[i].cyc);
            chk($sformatf("powerup_row%0d", i), int'(outs()), int'(pu_tab[i].exp));
            pll_locked = pu_tab[i].lock;
        end
        chk("powerup_loss", int'(lock_loss_cnt), 0);

        // never lock: pll_rst high 0-3, 104-107, 208-211
        do_reset();
        goto(103); chk("nolock_103", int'(outs()), 5'b00000);
        goto(104); chk("nolock_104", int'(outs()), 5'b10000);
        goto(107); chk("nolock_107", int'(outs()), 5'b10000);
        goto(108); chk("nolock_108", int'(outs()), 5'b00000);
        goto(207); chk("nolock_207", int'(outs()), 5'b00000);
        goto(208); chk("nolock_208", int'(outs()), 5'b10000);

        // lock glitch: high from 19, low in cycle 29, high from 30 -> sys at 49
        do_reset();
        goto(19); pll_locked = 1'b1;
        goto(29); pll_locked = 1'b0;
        goto(30); pll_locked = 1'b1;
        goto(38); chk("glitch_38", int'(outs()), 5'b00000);
        goto(48); chk("glitch_48", int'(outs()), 5'b00000);
        goto(49); chk("glitch_49", int'(outs()), 5'b01000);
        goto(65); chk("glitch_run", int'(outs()), 5'b01111);

        // lock drop in RUN at cycle 70 -> all low at 73
        goto(70); pll_locked = 1'b0;
        goto(72); chk("drop_72", int'(outs()), 5'b01111);
        goto(73); chk("drop_73", int'(outs()), 5'b00000);
        chk("drop_loss", int'(lock_loss_cnt), 1);
        goto(80); pll_locked = 1'b1;
        goto(98);  chk("relock_98",  int'(outs()), 5'b00000);
        goto(99);  chk("relock_99",  int'(outs()), 5'b01000);
        goto(107); chk("relock_107", int'(outs()), 5'b01100);
        goto(115); chk("relock_115", int'(outs()), 5'b01111);

        // sw reset in RUN: pulse seen at 121 -> low at 121, sys back at 137
        goto(120); sw_reset_req = 1'b1;
        goto(121); sw_reset_req = 1'b0;
        chk("sw_121", int'(outs()), 5'b00000);
        goto(136); chk("sw_136", int'(outs()), 5'b00000);
        goto(137); chk("sw_137", int'(outs()), 5'b01000);
        goto(153); chk("sw_153", int'(outs()), 5'b01111);
        chk("sw_loss", int'(lock_loss_cnt), 1);

        // lock loss and sw request on the same edge (163): loss wins
        goto(160); pll_locked = 1'b0;
        goto(162); sw_reset_req = 1'b1;
        goto(163); sw_reset_req = 1'b0;
        chk("prio_163", int'(outs()), 5'b00000);
        chk("prio_loss", int'(lock_loss_cnt), 2);
        goto(170); chk("prio_170", int'(outs()), 5'b00000);
        pll_locked = 1'b1;
        goto(189); chk("prio_189", int'(outs()), 5'b01000);
        goto(205); chk("prio_205", int'(outs()), 5'b01111);

        // 300 more lock losses from RUN: count 2 -> saturates at 255
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_sig(0, 1'b0, 6, "sat_drop");
            pll_locked = 1'b1;
            wait_sig(2, 1'b1, 60, "sat_run");
            if (i == 99)  chk("sat_102", int'(lock_loss_cnt), 102);
            if (i == 252) chk("sat_255", int'(lock_loss_cnt), 255);
        end
        chk("sat_final", int'(lock_loss_cnt), 255);

        // async reset pulse in REL_CPU0
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        wait_sig(0, 1'b1, 30, "mid_sys");
        wait_sig(1, 1'b1, 12, "mid_cpu0");
        step(); step(); step();
        chk("mid_relcpu0", int'(outs()), 5'b01100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", int'(outs()), 5'b10000);
        chk("mid_rst_loss", int'(lock_loss_cnt), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_outs", int'(outs()), 5'b10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
